// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-side arbiter sharing one FIFO write port
// among NUM_REQ valid/ready producers. Each grant lasts up to MAX_BURST words.
// Write strobe and data to the FIFO are registered. The full/almostfull flags
// throttle the producers so that a write is never presented against a full FIFO.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          busy,
    output logic                          err_overflow
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]  data_q, data_d;
    logic                   err_q, err_d;

    logic [FIFO_WIDTH-1:0]  req_data_arr [NUM_REQ];
    logic [IDX_W-1:0]       owner_idx;
    logic                   owner_req;
    logic                   space_ok;
    logic                   xfer;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    int                     cand;
    logic [NUM_REQ-1:0]     req_sh;

    // A write already in flight while almostfull would consume the last free
    // slot, so the guard looks at the registered strobe as well as the flags.
    assign space_ok = !rst && (state_q == ST_GRANT) && !fifo_full
                      && !(fifo_almostfull && wr_en_q);

    // Per-producer data slices and ready: only the owner ever sees ready.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prod
            assign req_data_arr[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
            assign req_ready[gi]    = grant_q[gi] & space_ok;
        end
    endgenerate

    // Encode the one-hot grant into the owner index.
    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                owner_idx = IDX_W'(k);
            end
        end
    end

    assign owner_req = req[owner_idx];
    assign xfer      = |(req & req_ready);

    // Round-robin search: first requester upward from last+1, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        req_sh     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand   = (int'(last_q) + k) % NUM_REQ;
            req_sh = req >> cand;
            if (!pick_found && req_sh[0]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        wr_en_d     = 1'b0;
        data_d      = data_q;
        err_d       = err_q | fifo_overflow;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_GRANT;
                    grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    wr_en_d     = 1'b1;
                    data_d      = req_data_arr[owner_idx];
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                // Release on the final beat of a burst or when the owner goes quiet.
                if ((xfer && (burst_cnt_q == LAST_BEAT)) || !owner_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register with synchronous reset; pointer restarts so producer 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= LAST_IDX;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign grant        = grant_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign busy         = (state_q == ST_GRANT);
    assign err_overflow = err_q;

endmodule
